// File: rtl/multi_stage_trigger_capture.sv
// Logic-analyser trigger/capture engine: circular capture RAM, pre-trigger depth,
// up to STAGES-deep masked sequence trigger, linearised readout. Optional macro: TRIG_TIMEOUT_EN.
module multi_stage_trigger_capture #(
    parameter int CH_W   = 8,
    parameter int ADDR_W = 6,
    parameter int STAGES = 4
`ifdef TRIG_TIMEOUT_EN
    ,
    parameter int TIMEOUT = 1024
`endif
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              sample_en,
    input  logic [CH_W-1:0]   din,
    input  logic              arm,
    input  logic              abort,
    input  logic              cfg_we,
    input  logic [1:0]        cfg_sel,
    input  logic [CH_W-1:0]   cfg_pattern,
    input  logic [CH_W-1:0]   cfg_mask,
    input  logic [1:0]        stage_cnt,
    input  logic [ADDR_W-1:0] pre_len,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [CH_W-1:0]   rd_data,
    output logic              busy,
    output logic              triggered,
    output logic              done,
    output logic [ADDR_W-1:0] trig_addr,
    output logic              timed_out
);

    localparam int DEPTH = 1 << ADDR_W;

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_PRE   = 3'd1;
    localparam logic [2:0] S_ARMED = 3'd2;
    localparam logic [2:0] S_POST  = 3'd3;
    localparam logic [2:0] S_DONE  = 3'd4;

    localparam logic [1:0]        STAGE_MAX = 2'(STAGES - 1);
    localparam logic [ADDR_W:0]   DEPTH_C   = (ADDR_W + 1)'(DEPTH);
    localparam logic [ADDR_W:0]   CNT_ONE   = (ADDR_W + 1)'(1);
    localparam logic [ADDR_W-1:0] PTR_ONE   = ADDR_W'(1);

    function automatic logic f_match(input logic [CH_W-1:0] d,
                                     input logic [CH_W-1:0] p,
                                     input logic [CH_W-1:0] m);
        return (((d ^ p) & m) == {CH_W{1'b0}});
    endfunction

    logic [CH_W-1:0]   mem [DEPTH];

    logic [2:0]        state_q, state_d;
    logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_W:0]   cnt_q, cnt_d;
    logic [1:0]        stage_q, stage_d;
    logic [1:0]        stage_cnt_q, stage_cnt_d;
    logic [ADDR_W-1:0] pre_len_q, pre_len_d;
    logic [CH_W-1:0]   pattern_q [STAGES];
    logic [CH_W-1:0]   pattern_d [STAGES];
    logic [CH_W-1:0]   mask_q [STAGES];
    logic [CH_W-1:0]   mask_d [STAGES];
    logic [ADDR_W-1:0] trig_addr_q, trig_addr_d;
    logic              triggered_q, triggered_d;
    logic              done_q, done_d;
    logic              busy_q, busy_d;
    logic [CH_W-1:0]   rd_data_q, rd_data_d;

    logic              mem_we_s;
    logic [3:0]        match_vec_s;
    logic              cur_match_s;
    logic              hit_s;
    logic              force_s;
    logic [ADDR_W:0]   post_total_s;
    logic [ADDR_W-1:0] rd_idx_s;

`ifdef TRIG_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT + 1);
    logic [TW-1:0] tcnt_q, tcnt_d;
    logic          timed_out_q, timed_out_d;
`endif

    // Per-stage pattern comparison of the current probe sample
    always_comb begin
        match_vec_s = 4'b0000;
        for (int s = 0; s < STAGES; s++) begin
            match_vec_s[s] = f_match(din, pattern_q[s], mask_q[s]);
        end
    end

    assign cur_match_s  = match_vec_s[stage_q];
    assign hit_s        = cur_match_s && (stage_q == stage_cnt_q);
    assign post_total_s = DEPTH_C - {1'b0, pre_len_q};
    assign rd_idx_s     = trig_addr_q - pre_len_q + rd_addr;

`ifdef TRIG_TIMEOUT_EN
    assign force_s = !hit_s && (tcnt_q == TW'(TIMEOUT - 1));
`else
    assign force_s = 1'b0;
`endif

    // Capture FSM, pointer/counter bookkeeping and configuration writes
    always_comb begin
        state_d     = state_q;
        wr_ptr_d    = wr_ptr_q;
        cnt_d       = cnt_q;
        stage_d     = stage_q;
        stage_cnt_d = stage_cnt_q;
        pre_len_d   = pre_len_q;
        trig_addr_d = trig_addr_q;
        triggered_d = triggered_q;
        done_d      = done_q;
        pattern_d   = pattern_q;
        mask_d      = mask_q;
        mem_we_s    = 1'b0;
`ifdef TRIG_TIMEOUT_EN
        tcnt_d      = tcnt_q;
        timed_out_d = timed_out_q;
`endif

        case (state_q)
            S_IDLE, S_DONE: begin
                if (arm) begin
                    pre_len_d   = pre_len;
                    stage_cnt_d = (stage_cnt > STAGE_MAX) ? STAGE_MAX : stage_cnt;
                    wr_ptr_d    = {ADDR_W{1'b0}};
                    cnt_d       = {(ADDR_W + 1){1'b0}};
                    stage_d     = 2'd0;
                    triggered_d = 1'b0;
                    done_d      = 1'b0;
`ifdef TRIG_TIMEOUT_EN
                    tcnt_d      = {TW{1'b0}};
                    timed_out_d = 1'b0;
`endif
                    state_d     = (pre_len == {ADDR_W{1'b0}}) ? S_ARMED : S_PRE;
                end else begin
                    state_d = state_q;
                end
            end
            S_PRE: begin
                if (sample_en) begin
                    mem_we_s = 1'b1;
                    wr_ptr_d = wr_ptr_q + PTR_ONE;
                    if ((cnt_q + CNT_ONE) == {1'b0, pre_len_q}) begin
                        cnt_d   = {(ADDR_W + 1){1'b0}};
                        state_d = S_ARMED;
                    end else begin
                        cnt_d = cnt_q + CNT_ONE;
                    end
                end else begin
                    state_d = S_PRE;
                end
            end
            S_ARMED: begin
                if (sample_en) begin
                    mem_we_s = 1'b1;
                    wr_ptr_d = wr_ptr_q + PTR_ONE;
                    if (hit_s || force_s) begin
                        trig_addr_d = wr_ptr_q;
                        triggered_d = 1'b1;
                        stage_d     = 2'd0;
`ifdef TRIG_TIMEOUT_EN
                        timed_out_d = force_s;
`endif
                        // The trigger sample is itself the first post sample.
                        if (post_total_s == CNT_ONE) begin
                            done_d  = 1'b1;
                            state_d = S_DONE;
                        end else begin
                            cnt_d   = CNT_ONE;
                            state_d = S_POST;
                        end
                    end else if (cur_match_s) begin
                        stage_d = stage_q + 2'd1;
`ifdef TRIG_TIMEOUT_EN
                        tcnt_d  = {TW{1'b0}};
`endif
                    end else begin
                        stage_d = match_vec_s[0] ? 2'd1 : 2'd0;
`ifdef TRIG_TIMEOUT_EN
                        tcnt_d  = tcnt_q + TW'(1);
`endif
                    end
                end else begin
                    state_d = S_ARMED;
                end
            end
            S_POST: begin
                if (sample_en) begin
                    mem_we_s = 1'b1;
                    wr_ptr_d = wr_ptr_q + PTR_ONE;
                    if ((cnt_q + CNT_ONE) == post_total_s) begin
                        done_d  = 1'b1;
                        state_d = S_DONE;
                    end else begin
                        cnt_d = cnt_q + CNT_ONE;
                    end
                end else begin
                    state_d = S_POST;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        if (abort) begin
            state_d     = S_IDLE;
            mem_we_s    = 1'b0;
            wr_ptr_d    = wr_ptr_q;
            triggered_d = 1'b0;
            done_d      = 1'b0;
`ifdef TRIG_TIMEOUT_EN
            timed_out_d = 1'b0;
`endif
        end else begin
            mem_we_s = mem_we_s;
        end

        if (cfg_we && !busy_q && (32'(cfg_sel) < STAGES)) begin
            for (int s = 0; s < STAGES; s++) begin
                if (32'(cfg_sel) == s) begin
                    pattern_d[s] = cfg_pattern;
                    mask_d[s]    = cfg_mask;
                end else begin
                    pattern_d[s] = pattern_q[s];
                end
            end
        end else begin
            pattern_d = pattern_q;
        end

        busy_d = (state_d == S_PRE) || (state_d == S_ARMED) || (state_d == S_POST);

        if (state_q == S_DONE) begin
            rd_data_d = mem[rd_idx_s];
        end else begin
            rd_data_d = rd_data_q;
        end
    end

    // Capture RAM write port; contents survive reset
    always_ff @(posedge clk) begin
        if (rst_n && mem_we_s) begin
            mem[wr_ptr_q] <= din;
        end
    end

    // State and output registers with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            wr_ptr_q    <= {ADDR_W{1'b0}};
            cnt_q       <= {(ADDR_W + 1){1'b0}};
            stage_q     <= 2'd0;
            stage_cnt_q <= 2'd0;
            pre_len_q   <= {ADDR_W{1'b0}};
            trig_addr_q <= {ADDR_W{1'b0}};
            triggered_q <= 1'b0;
            done_q      <= 1'b0;
            busy_q      <= 1'b0;
            rd_data_q   <= {CH_W{1'b0}};
            for (int s = 0; s < STAGES; s++) begin
                pattern_q[s] <= {CH_W{1'b0}};
                mask_q[s]    <= {CH_W{1'b0}};
            end
`ifdef TRIG_TIMEOUT_EN
            tcnt_q      <= {TW{1'b0}};
            timed_out_q <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            wr_ptr_q    <= wr_ptr_d;
            cnt_q       <= cnt_d;
            stage_q     <= stage_d;
            stage_cnt_q <= stage_cnt_d;
            pre_len_q   <= pre_len_d;
            trig_addr_q <= trig_addr_d;
            triggered_q <= triggered_d;
            done_q      <= done_d;
            busy_q      <= busy_d;
            rd_data_q   <= rd_data_d;
            pattern_q   <= pattern_d;
            mask_q      <= mask_d;
`ifdef TRIG_TIMEOUT_EN
            tcnt_q      <= tcnt_d;
            timed_out_q <= timed_out_d;
`endif
        end
    end

    assign rd_data   = rd_data_q;
    assign busy      = busy_q;
    assign triggered = triggered_q;
    assign done      = done_q;
    assign trig_addr = trig_addr_q;
`ifdef TRIG_TIMEOUT_EN
    assign timed_out = timed_out_q;
`else
    assign timed_out = 1'b0;
`endif

endmodule

// File: tb/tb_multi_stage_trigger_capture.sv
// Self-checking bench for multi_stage_trigger_capture: directed scenarios plus randomized
// captures checked against a sample-history reference model.
module tb_multi_stage_trigger_capture;

    localparam int CH_W   = 8;
    localparam int ADDR_W = 6;
    localparam int DEPTH  = 64;
    localparam int STAGES = 4;
`ifdef TRIG_TIMEOUT_EN
    localparam int TO = 16;
`endif

    logic              clk;
    logic              rst_n;
    logic              sample_en;
    logic [CH_W-1:0]   din;
    logic              arm;
    logic              abort;
    logic              cfg_we;
    logic [1:0]        cfg_sel;
    logic [CH_W-1:0]   cfg_pattern;
    logic [CH_W-1:0]   cfg_mask;
    logic [1:0]        stage_cnt;
    logic [ADDR_W-1:0] pre_len;
    logic [ADDR_W-1:0] rd_addr;
    logic [CH_W-1:0]   rd_data;
    logic              busy;
    logic              triggered;
    logic              done;
    logic [ADDR_W-1:0] trig_addr;
    logic              timed_out;

    multi_stage_trigger_capture #(
        .CH_W(CH_W), .ADDR_W(ADDR_W), .STAGES(STAGES)
`ifdef TRIG_TIMEOUT_EN
        , .TIMEOUT(TO)
`endif
    ) dut (
        .clk(clk), .rst_n(rst_n), .sample_en(sample_en), .din(din), .arm(arm),
        .abort(abort), .cfg_we(cfg_we), .cfg_sel(cfg_sel), .cfg_pattern(cfg_pattern),
        .cfg_mask(cfg_mask), .stage_cnt(stage_cnt), .pre_len(pre_len), .rd_addr(rd_addr),
        .rd_data(rd_data), .busy(busy), .triggered(triggered), .done(done),
        .trig_addr(trig_addr), .timed_out(timed_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int passed = 0;
    int total  = 0;
    int fails  = 0;
    logic [7:0] pat [4];
    logic [7:0] msk [4];
    logic [7:0] hist [$];
    logic [7:0] prefix [$];
    logic [7:0] rdbuf [64];
    int last_k;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        total++;
        assert (obs === expv) begin
            passed++;
        end else begin
            fails++;
            $error("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, expv);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic cfg(input int s, input logic [7:0] p, input logic [7:0] m);
        cfg_we = 1'b1; cfg_sel = 2'(s); cfg_pattern = p; cfg_mask = m;
        step();
        cfg_we = 1'b0;
        pat[s] = p; msk[s] = m;
    endtask

    task automatic feed(input logic [7:0] d);
        sample_en = 1'b1; din = d;
        step();
        sample_en = 1'b0;
    endtask

    function automatic bit mt(input logic [7:0] d, input int s);
        return ((d ^ pat[s]) & msk[s]) == 8'h00;
    endfunction

    // Index of the trigger sample within the history, -1 if none.
    function automatic int model_trig(input int pre, input int sc, output bit forced);
        int st = 0;
        int tc = 0;
        forced = 1'b0;
        for (int n = pre; n < hist.size(); n++) begin
            if (mt(hist[n], st) && st == sc) return n;
`ifdef TRIG_TIMEOUT_EN
            if (tc + 1 >= TO) begin
                forced = 1'b1;
                return n;
            end
`endif
            if (mt(hist[n], st)) begin
                st++;
                tc = 0;
            end else begin
                st = mt(hist[n], 0) ? 1 : 0;
                tc++;
            end
        end
        return -1;
    endfunction

    task automatic run_capture(input int pre, input int sc, input int en_pct, input string tag);
        int  k;
        int  cyc;
        bit  seen;
        bit  forced;
        hist.delete();
        pre_len = 6'(pre); stage_cnt = 2'(sc); arm = 1'b1; sample_en = 1'b0;
        step();
        arm = 1'b0;
        check({tag, " busy_after_arm"}, 32'(busy), 32'd1);
        seen = 1'b0;
        cyc  = 0;
        while (!done && cyc < 4000) begin
            sample_en = ($urandom_range(99) < en_pct);
            if (sample_en) begin
                if (prefix.size() > 0) din = prefix.pop_front();
                else din = 8'($urandom);
                hist.push_back(din);
            end else begin
                din = 8'($urandom);
            end
            step();
            cyc++;
            if (triggered && !seen) begin
                seen = 1'b1;
                k = model_trig(pre, sc, forced);
                check({tag, " trig_index"}, 32'(hist.size() - 1), 32'(k));
                check({tag, " trig_addr"}, 32'(trig_addr), 32'(k % DEPTH));
                check({tag, " timed_out"}, 32'(timed_out), 32'(forced));
            end
        end
        sample_en = 1'b0;
        prefix.delete();
        k = model_trig(pre, sc, forced);
        last_k = k;
        check({tag, " done"}, 32'(done), 32'd1);
        check({tag, " busy_at_done"}, 32'(busy), 32'd0);
        check({tag, " triggered_at_done"}, 32'(triggered), 32'd1);
        check({tag, " sample_count"}, 32'(hist.size()), 32'(k + DEPTH - pre));
        if (k >= 0) begin
            for (int a = 0; a < DEPTH; a++) begin
                rd_addr = 6'(a);
                step();
                rdbuf[a] = rd_data;
                if (k - pre + a < hist.size())
                    check({tag, " readout"}, 32'(rd_data), 32'(hist[k - pre + a]));
            end
        end
    endtask

    initial begin
        rst_n = 1'b0; sample_en = 1'b0; din = 8'h00; arm = 1'b0; abort = 1'b0;
        cfg_we = 1'b0; cfg_sel = 2'd0; cfg_pattern = 8'h00; cfg_mask = 8'h00;
        stage_cnt = 2'd0; pre_len = 6'd0; rd_addr = 6'd0; last_k = -1;
        for (int s = 0; s < 4; s++) begin pat[s] = 8'h00; msk[s] = 8'h00; end
        step(); step(); step();
        check("reset busy", 32'(busy), 32'd0);
        check("reset triggered", 32'(triggered), 32'd0);
        check("reset done", 32'(done), 32'd0);
        check("reset trig_addr", 32'(trig_addr), 32'd0);
        check("reset timed_out", 32'(timed_out), 32'd0);
        check("reset rd_data", 32'(rd_data), 32'd0);
        rst_n = 1'b1;
        step();

        // Single-word trigger on an incrementing counter
        cfg(0, 8'hA5, 8'hFF);
        for (int i = 0; i < 256; i++) prefix.push_back(8'(i));
        run_capture(8, 0, 100, "t1");
`ifndef TRIG_TIMEOUT_EN
        check("t1 k", 32'(last_k), 32'd165);
        check("t1 addr0", 32'(rdbuf[0]), 32'h9D);
        check("t1 addr8", 32'(rdbuf[8]), 32'hA5);
        check("t1 addr63", 32'(rdbuf[63]), 32'hDC);
`endif

        // Three-stage sequence with restart, back-to-back and with sample gaps
        cfg(0, 8'h02, 8'h03); cfg(1, 8'h01, 8'h03); cfg(2, 8'h02, 8'h03);
        prefix = '{8'h02, 8'h01, 8'h03, 8'h02, 8'h01, 8'h02};
        run_capture(0, 2, 100, "t2");
        check("t2 k", 32'(last_k), 32'd5);
        prefix = '{8'h02, 8'h01, 8'h03, 8'h02, 8'h01, 8'h02};
        run_capture(0, 2, 50, "t2gap");
        check("t2gap k", 32'(last_k), 32'd5);

        // Mask of zero with no pre-trigger region
        cfg(0, 8'h00, 8'h00);
        prefix = '{8'h3C};
        run_capture(0, 0, 100, "t3");
        check("t3 k", 32'(last_k), 32'd0);
        check("t3 addr0", 32'(rdbuf[0]), 32'h3C);

        // Randomized captures
        for (int r = 0; r < 6; r++) begin
            for (int s = 0; s < 4; s++) cfg(s, 8'($urandom), 8'($urandom) & 8'h03);
            run_capture($urandom_range(63), $urandom_range(3), 70, "rand");
        end

        // cfg during ARMED and arm during POST ignored; abort beats sample_en
        cfg(0, 8'h5A, 8'hFF);
        pre_len = 6'd0; stage_cnt = 2'd0; arm = 1'b1; step(); arm = 1'b0;
        feed(8'h00); feed(8'h01); feed(8'h02);
        cfg_we = 1'b1; cfg_sel = 2'd0; cfg_pattern = 8'h11; cfg_mask = 8'hFF;
        step();
        cfg_we = 1'b0;
        feed(8'h11);
        check("t4 no_trig_on_ignored_cfg", 32'(triggered), 32'd0);
        check("t4 busy_armed", 32'(busy), 32'd1);
        feed(8'h5A);
        check("t4 trig", 32'(triggered), 32'd1);
        check("t4 trig_addr", 32'(trig_addr), 32'd4);
        pre_len = 6'd5; arm = 1'b1; step(); arm = 1'b0;
        check("t4 arm_in_post busy", 32'(busy), 32'd1);
        check("t4 arm_in_post triggered", 32'(triggered), 32'd1);
        check("t4 arm_in_post trig_addr", 32'(trig_addr), 32'd4);
        feed(8'h77);
        abort = 1'b1; sample_en = 1'b1; din = 8'h99;
        step();
        abort = 1'b0; sample_en = 1'b0;
        check("t4 abort busy", 32'(busy), 32'd0);
        check("t4 abort done", 32'(done), 32'd0);
        check("t4 abort triggered", 32'(triggered), 32'd0);
        step();
        check("t4 idle_after_abort", 32'(busy), 32'd0);

        // Reset mid-POST clears outputs and patterns
        cfg(0, 8'h77, 8'hFF);
        pre_len = 6'd0; stage_cnt = 2'd0; arm = 1'b1; step(); arm = 1'b0;
        feed(8'h77); feed(8'h01); feed(8'h02);
        check("t5 busy_post", 32'(busy), 32'd1);
        rst_n = 1'b0; step(); rst_n = 1'b1;
        for (int s = 0; s < 4; s++) begin pat[s] = 8'h00; msk[s] = 8'h00; end
        check("t5 rst busy", 32'(busy), 32'd0);
        check("t5 rst triggered", 32'(triggered), 32'd0);
        check("t5 rst done", 32'(done), 32'd0);
        check("t5 rst trig_addr", 32'(trig_addr), 32'd0);
        check("t5 rst timed_out", 32'(timed_out), 32'd0);
        arm = 1'b1; step(); arm = 1'b0;
        feed(8'h00);
        check("t5 cleared_mask_matches", 32'(triggered), 32'd1);
        abort = 1'b1; step(); abort = 1'b0;

`ifdef TRIG_TIMEOUT_EN
        cfg(0, 8'hFF, 8'hFF);
        pre_len = 6'd0; stage_cnt = 2'd0; arm = 1'b1; step(); arm = 1'b0;
        for (int i = 0; i < 15; i++) feed(8'h00);
        check("to not_yet", 32'(triggered), 32'd0);
        feed(8'h00);
        check("to triggered", 32'(triggered), 32'd1);
        check("to timed_out", 32'(timed_out), 32'd1);
        check("to trig_addr", 32'(trig_addr), 32'd15);
        abort = 1'b1; step(); abort = 1'b0;
        check("to cleared_by_abort", 32'(timed_out), 32'd0);
`endif

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/multi_stage_trigger_capture.md
Name: multi_stage_trigger_capture

Overview:
Parametrised trigger-and-capture engine for the logic-analyser datapath. It samples a CH_W-bit probe bus into a circular capture RAM with a programmable pre-trigger depth. It fires on a 1..STAGES-deep sequence of masked pattern matches on consecutive samples. After the capture completes, it presents the buffer linearised (oldest pre-trigger sample at address 0) to the VGA readout.

Parameters:
CH_W, 8, probe channel count (bits per sample)
ADDR_W, 6, capture RAM address width; DEPTH = 2**ADDR_W
STAGES, 4, maximum trigger sequence stages (1..4)

Ports:
clk  in  1  system clock
rst_n  in  1  reset, synchronous, active-low
sample_en  in  1  sample strobe; one sample per high cycle
din  in  CH_W  probe data
arm  in  1  start-capture pulse
abort  in  1  cancel capture
cfg_we  in  1  stage pattern/mask write strobe
cfg_sel  in  2  stage index written
cfg_pattern  in  CH_W  expected value for stage
cfg_mask  in  CH_W  1 = bit compared, 0 = don't care
stage_cnt  in  2  active stages minus 1 (0 = single-word trigger)
pre_len  in  ADDR_W  pre-trigger sample count
rd_addr  in  ADDR_W  linear readout address
rd_data  out  CH_W  readout data, 1-cycle latency
busy  out  1  capture in progress
triggered  out  1  trigger condition met in current capture
done  out  1  buffer complete and readable
trig_addr  out  ADDR_W  physical RAM address of trigger sample
timed_out  out  1  forced trigger flag (optional feature)

Behaviour:
- Reset: state IDLE; all outputs 0; all patterns and masks 0; pointers and counters 0.
- States: IDLE, PRE, ARMED, POST, DONE. busy = PRE|ARMED|POST.
- arm in IDLE or DONE: latch pre_len (clamped to DEPTH-1) and stage_cnt (clamped to STAGES-1). Clear wr_ptr, fill count, stage, triggered, done. Go to PRE, or to ARMED if pre_len = 0. arm while busy is ignored.
- Every sample_en in PRE/ARMED/POST: mem[wr_ptr] <= din; wr_ptr++ mod DEPTH.
- PRE: after pre_len samples are written, go to ARMED. Samples written in PRE are not compared.
- ARMED: match(s) = ((din ^ pattern[s]) & mask[s]) == 0. Samples are written as a ring.
  - match(stage) and stage == stage_cnt: trigger. trig_addr <= wr_ptr of this sample; triggered <= 1; go to POST.
  - match(stage) and stage < stage_cnt: stage++.
  - Mismatch: stage <= (match(0) ? 1 : 0). If stage_cnt = 0, that same match(0) triggers instead.
  - Stages must match on consecutive sample_en samples. Cycles without sample_en do not reset the stage.
- POST: the trigger sample counts as post sample 1. After DEPTH - pre_len total post samples, go to DONE with done <= 1.
- Readout is valid in DONE: rd_data <= mem[(trig_addr - pre_len + rd_addr) mod DEPTH], registered. rd_addr = pre_len returns the trigger sample. rd_data is undefined outside DONE.
- cfg_we writes pattern[cfg_sel] and mask[cfg_sel] only when not busy. Ignored when busy or when cfg_sel >= STAGES.
- abort: go to IDLE next cycle; clear busy, done, triggered. Takes priority over arm and sample_en in the same cycle.
- Reset mid-capture: same as power-on reset. RAM contents are not cleared.
- A mask of all zeros matches any sample.

Optional Feature:
TRIG_TIMEOUT_EN
- Defined: adds parameter TIMEOUT, default 1024. Counts sample_en strobes in ARMED; the counter clears whenever stage advances. When the count reaches TIMEOUT, the current sample is a forced trigger: timed_out <= 1 plus the normal trigger actions. timed_out clears on arm, abort or reset.
- Undefined: no counter; timed_out is tied 0.

Test Plan:
- DEPTH 64, pre_len 8, stage_cnt 0, pattern 0xA5, mask 0xFF, din = incrementing counter from 0x00 on every cycle with sample_en=1 -> trigger on 0xA5; done after 56 post samples. Readout: addr 0 = 0x9D, addr 8 = 0xA5, addr 63 = 0xDC.
- 3-stage sequence: stage_cnt 2, patterns 0x02/0x01/0x02, mask 0x03, din[1:0] sequence 2,1,3,2,1,2 -> stage resets at the 3; trigger only on the sixth sample.
- mask 0x00, pre_len 0 -> trigger on first sample after arm; trig_addr = 0; readout addr 0 = that sample.
- cfg_we during ARMED and arm during POST -> both ignored; abort in the same cycle as sample_en in POST -> IDLE next cycle, busy = done = triggered = 0.
- rst_n low mid-POST -> all outputs 0 next cycle; patterns cleared. With TRIG_TIMEOUT_EN and TIMEOUT = 16, a never-matching pattern -> forced trigger on the 16th armed sample; timed_out = 1.
